// File: rtl/fxp_mat_pkg.sv
// Shared types and constants for the sequential 4x4 fixed-point matrix multiplier.
// MAT4_MUL_SEQ_PIPE_MULT_EN adds a multiplier pipeline stage (one drain cycle per element).
package fxp_mat_pkg;

  localparam int N_ELEM = 16;
  localparam int N_DIM  = 4;
  localparam int WI_DEF = 8;
  localparam int WF_DEF = 8;

  typedef logic [N_ELEM-1:0][WI_DEF+WF_DEF-1:0] mat4_t;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} mat_seq_state_t;

  // Last k value spent in MAC; the piped build needs one extra cycle to drain the product.
`ifdef MAT4_MUL_SEQ_PIPE_MULT_EN
  localparam int K_LAST = N_DIM;
`else
  localparam int K_LAST = N_DIM - 1;
`endif

endpackage

// File: rtl/fxp_mac.sv
// Signed multiply-accumulate with round-half-up and saturating output stage.
// MAT4_MUL_SEQ_PIPE_MULT_EN registers the product before it reaches the accumulator.
module fxp_mac #(
  parameter int WI = 8,
  parameter int WF = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    clr,
  input  logic                    mul_en,
  input  logic signed [WI+WF-1:0] a,
  input  logic signed [WI+WF-1:0] b,
  output logic        [WI+WF-1:0] out,
  output logic                    sat
);

  localparam int W  = WI + WF;
  localparam int PW = 2 * W;
  localparam int AW = PW + 2;

  localparam logic signed [AW:0] HALF = {{(AW-WF+1){1'b0}}, 1'b1, {(WF-1){1'b0}}};
  localparam logic signed [AW:0] MAXV = {{(AW-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW-W+2){1'b1}}, {(W-1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] add_term;
  logic                 add_en;
  logic signed [AW-1:0] acc;
  logic signed [AW:0]   rnd_sum;
  logic signed [AW:0]   rnd_shift;
  logic                 sat_hi;
  logic                 sat_lo;

  assign prod = a * b;

`ifdef MAT4_MUL_SEQ_PIPE_MULT_EN
  logic signed [PW-1:0] prod_q;
  logic                 prod_vld;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= mul_en;
      if (mul_en) prod_q <= prod;
    end
  end

  assign add_term = prod_q;
  assign add_en   = prod_vld;
`else
  assign add_term = prod;
  assign add_en   = mul_en;
`endif

  // clr wins so a new element never inherits a late product
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       acc <= '0;
    else if (clr)    acc <= '0;
    else if (add_en) acc <= acc + {{2{add_term[PW-1]}}, add_term};
  end

  assign rnd_sum   = {acc[AW-1], acc} + HALF;
  assign rnd_shift = rnd_sum >>> WF;
  assign sat_hi    = rnd_shift > MAXV;
  assign sat_lo    = rnd_shift < MINV;
  assign sat       = sat_hi | sat_lo;

  always_comb begin
    out = rnd_shift[W-1:0];
    if (sat_hi)      out = MAXV[W-1:0];
    else if (sat_lo) out = MINV[W-1:0];
  end

endmodule

// File: rtl/mat4_mul_seq.sv
// 4x4 fixed-point matrix product R = A x B through one shared MAC unit.
// MAT4_MUL_SEQ_PIPE_MULT_EN selects the pipelined multiplier (6 cycles per element).
//
//   state | meaning
//   IDLE  | waiting for start
//   MAC   | accumulating A[r][k]*B[k][c] (plus drain cycle when piped)
//   WRITE | round/saturate accumulator into result[i]
//   DONE  | one-cycle done pulse, result_valid set
module mat4_mul_seq
  import fxp_mat_pkg::*;
#(
  parameter int WI = 8,
  parameter int WF = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [15:0][WI+WF-1:0] mat_a,
  input  logic [15:0][WI+WF-1:0] mat_b,
  output logic                   busy,
  output logic                   done,
  output logic                   result_valid,
  output logic [15:0][WI+WF-1:0] result,
  output logic                   overflow
);

  localparam int W = WI + WF;

  mat_seq_state_t state, state_nx;

  logic [15:0][W-1:0] a_q, b_q;
  logic [3:0]         idx;
  logic [2:0]         k;
  logic               start_ok;
  logic               mul_en;
  logic               acc_clr;
  logic [W-1:0]       a_sel, b_sel;
  logic [W-1:0]       mac_out;
  logic               mac_sat;

  assign start_ok = start && (state == IDLE || state == DONE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (k == 3'(K_LAST)) state_nx = WRITE;
      WRITE:   state_nx = (idx == 4'd15) ? DONE : MAC;
      DONE:    state_nx = start ? MAC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == MAC) || (state == WRITE);
    done    = (state == DONE);
    mul_en  = (state == MAC) && (k < 3'(N_DIM));
    acc_clr = start_ok || (state == WRITE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q          <= '0;
      b_q          <= '0;
      idx          <= '0;
      k            <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else if (start_ok) begin
      a_q          <= mat_a;
      b_q          <= mat_b;
      idx          <= '0;
      k            <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else if (state == MAC) begin
      k <= k + 3'd1;
    end else if (state == WRITE) begin
      result[idx] <= mac_out;
      if (mac_sat) overflow <= 1'b1;
      if (idx == 4'd15) result_valid <= 1'b1;
      idx <= idx + 4'd1;
      k   <= '0;
    end
  end

  // r = idx[3:2], c = idx[1:0]; k only reaches 4 on the drain cycle where mul_en is low
  assign a_sel = a_q[{idx[3:2], k[1:0]}];
  assign b_sel = b_q[{k[1:0], idx[1:0]}];

  fxp_mac #(.WI(WI), .WF(WF)) u_mac (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr    (acc_clr),
    .mul_en (mul_en),
    .a      (a_sel),
    .b      (b_sel),
    .out    (mac_out),
    .sat    (mac_sat)
  );

endmodule

// File: tb/tb_mat4_mul_seq.sv
// Scoreboard bench for mat4_mul_seq: expected products queued at start, compared at done.
module tb_mat4_mul_seq;
  import fxp_mat_pkg::*;

`ifdef MAT4_MUL_SEQ_PIPE_MULT_EN
  localparam int LAT = 97;
`else
  localparam int LAT = 81;
`endif

  logic  Clk, Reset, start;
  mat4_t mat_a, mat_b, result;
  logic  busy, done, result_valid, overflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    mat4_t r;
    bit    ovf;
  } exp_t;

  exp_t sb_q[$];

  mat4_mul_seq #(.WI(8), .WF(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .mat_a        (mat_a),
    .mat_b        (mat_b),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .result       (result),
    .overflow     (overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic exp_t model(input mat4_t a, input mat4_t b);
    exp_t   e;
    longint s, q;
    e.r   = '0;
    e.ovf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s = 0;
      for (int kk = 0; kk < 4; kk++)
        s += longint'($signed(a[(i/4)*4+kk])) * longint'($signed(b[kk*4+i%4]));
      q = (s + 128) >>> 8;
      if (q > 32767) begin q = 32767; e.ovf = 1'b1; end
      else if (q < -32768) begin q = -32768; e.ovf = 1'b1; end
      e.r[i] = q[15:0];
    end
    return e;
  endfunction

  function automatic mat4_t translate(input logic [15:0] tx, input logic [15:0] ty, input logic [15:0] tz);
    mat4_t m = '0;
    m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0100; m[15] = 16'h0100;
    m[3] = tx; m[7] = ty; m[11] = tz;
    return m;
  endfunction

  // Stimulus only: drives one operation and records what the DUT shows at each done pulse.
  task automatic run_op(input mat4_t a, input mat4_t b, input int poke_cyc, input bit hold,
                        input bit scramble, output int d1, output int d2, output int nd,
                        output mat4_t r1, output mat4_t r2, output bit ov1, output bit rv1);
    int win;
    win = hold ? 2*LAT + 4 : LAT + 4;
    @(negedge Clk);
    mat_a = a; mat_b = b; start = 1'b1;
    sb_q.push_back(model(a, b));
    if (hold) sb_q.push_back(model(a, b));
    @(posedge Clk); #1;
    d1 = 0; d2 = 0; nd = 0; r1 = '0; r2 = '0; ov1 = 1'b0; rv1 = 1'b0;
    for (int c = 1; c <= win; c++) begin
      if (done) begin
        nd++;
        if (nd == 1) begin d1 = c; r1 = result; ov1 = overflow; rv1 = result_valid; end
        else begin d2 = c; r2 = result; end
      end
      start = (c == poke_cyc) || (hold && (nd == 0 || c == d1));
      if (scramble && c == 10) begin mat_a = ~a; mat_b = {16{16'h1234}}; end
      @(posedge Clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
  endtask

  task automatic test_identity;
    int d1, d2, nd; mat4_t r1, r2, b; bit ov1, rv1; exp_t e;
    b = translate(16'hFF00, 16'hFE00, 16'hFD00);
    run_op(translate(16'h0000, 16'h0000, 16'h0000), b, 0, 0, 0, d1, d2, nd, r1, r2, ov1, rv1);
    e = sb_q.pop_front();
    checks++; if (d1 !== LAT) begin failures++; $display("FAIL ident_done_cycle got=%0d exp=%0d", d1, LAT); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL ident_done_count got=%0d exp=1", nd); end
    checks++; if (r1 !== e.r) begin failures++; $display("FAIL ident_result got=%h exp=%h", r1, e.r); end
    checks++; if (r1 !== b) begin failures++; $display("FAIL ident_equals_b got=%h exp=%h", r1, b); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL ident_ovf got=%b exp=0", ov1); end
    checks++; if (rv1 !== 1'b1) begin failures++; $display("FAIL ident_valid got=%b exp=1", rv1); end
    checks++; if (result !== b || result_valid !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL ident_hold got=%h/%b/%b exp=%h/1/0", result, result_valid, busy, b); end
  endtask

  task automatic test_translate;
    int d1, d2, nd; mat4_t r1, r2; bit ov1, rv1; exp_t e;
    run_op(translate(16'hFF00, 16'hFE00, 16'hFD00), translate(16'hFC00, 16'h0000, 16'h0080),
           0, 0, 0, d1, d2, nd, r1, r2, ov1, rv1);
    e = sb_q.pop_front();
    checks++; if (r1 !== e.r) begin failures++; $display("FAIL trans_result got=%h exp=%h", r1, e.r); end
    checks++; if (r1[3] !== 16'hFB00 || r1[7] !== 16'hFE00 || r1[11] !== 16'hFD80)
      begin failures++; $display("FAIL trans_col3 got=%h/%h/%h exp=fb00/fe00/fd80", r1[3], r1[7], r1[11]); end
    checks++; if (r1[0] !== 16'h0100 || r1[5] !== 16'h0100 || r1[15] !== 16'h0100 || r1[1] !== 16'h0000)
      begin failures++; $display("FAIL trans_diag got=%h exp=diag 0100", r1); end
  endtask

  task automatic test_saturate;
    int d1, d2, nd; mat4_t r1, r2; bit ov1, rv1; exp_t e;
    run_op({16{16'h7F00}}, {16{16'h7F00}}, 0, 0, 0, d1, d2, nd, r1, r2, ov1, rv1);
    e = sb_q.pop_front();
    checks++; if (r1 !== e.r || r1 !== {16{16'h7FFF}}) begin failures++; $display("FAIL sat_pos got=%h exp=%h", r1, e.r); end
    checks++; if (ov1 !== 1'b1 || ov1 !== e.ovf) begin failures++; $display("FAIL sat_pos_ovf got=%b exp=1", ov1); end
    run_op({16{16'h8000}}, {16{16'h7F00}}, 0, 0, 0, d1, d2, nd, r1, r2, ov1, rv1);
    e = sb_q.pop_front();
    checks++; if (r1 !== e.r || r1 !== {16{16'h8000}}) begin failures++; $display("FAIL sat_neg got=%h exp=%h", r1, e.r); end
    checks++; if (ov1 !== 1'b1) begin failures++; $display("FAIL sat_neg_ovf got=%b exp=1", ov1); end
  endtask

  task automatic test_rounding;
    int d1, d2, nd; mat4_t r1, r2, a, b; bit ov1, rv1; exp_t e;
    a = '0; b = '0; a[0] = 16'h0001; b[0] = 16'h0080;
    run_op(a, b, 0, 0, 0, d1, d2, nd, r1, r2, ov1, rv1);
    e = sb_q.pop_front();
    checks++; if (r1[0] !== 16'h0001 || r1 !== e.r) begin failures++; $display("FAIL round_pos got=%h exp=0001", r1[0]); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL round_pos_ovf got=%b exp=0", ov1); end
    a[0] = 16'hFFFF;
    run_op(a, b, 0, 0, 0, d1, d2, nd, r1, r2, ov1, rv1);
    e = sb_q.pop_front();
    checks++; if (r1[0] !== 16'h0000 || r1 !== e.r) begin failures++; $display("FAIL round_neg got=%h exp=0000", r1[0]); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL round_neg_ovf got=%b exp=0", ov1); end
  endtask

  task automatic test_busy_start;
    int d1, d2, nd; mat4_t r1, r2; bit ov1, rv1; exp_t e;
    run_op(translate(16'h0300, 16'h0000, 16'h0000), translate(16'h0000, 16'h0200, 16'hFF80),
           20, 0, 0, d1, d2, nd, r1, r2, ov1, rv1);
    e = sb_q.pop_front();
    checks++; if (nd !== 1 || d1 !== LAT) begin failures++; $display("FAIL busy_start got=%0d dones at %0d exp=1 at %0d", nd, d1, LAT); end
    checks++; if (r1 !== e.r) begin failures++; $display("FAIL busy_start_result got=%h exp=%h", r1, e.r); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, nd; mat4_t r1, r2, a, b; bit ov1, rv1; exp_t e1, e2;
    for (int i = 0; i < 16; i++) begin
      a[i] = 16'($urandom_range(0, 1023)) - 16'd512;
      b[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    end
    run_op(a, b, 0, 1, 0, d1, d2, nd, r1, r2, ov1, rv1);
    e1 = sb_q.pop_front();
    e2 = sb_q.pop_front();
    checks++; if (nd !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", nd); end
    checks++; if (d1 !== LAT || d2 !== 2*LAT) begin failures++; $display("FAIL b2b_cycles got=%0d,%0d exp=%0d,%0d", d1, d2, LAT, 2*LAT); end
    checks++; if (r1 !== e1.r) begin failures++; $display("FAIL b2b_first got=%h exp=%h", r1, e1.r); end
    checks++; if (r2 !== e2.r) begin failures++; $display("FAIL b2b_second got=%h exp=%h", r2, e2.r); end
  endtask

  task automatic test_input_change;
    int d1, d2, nd; mat4_t r1, r2, a, b; bit ov1, rv1; exp_t e;
    for (int i = 0; i < 16; i++) begin
      a[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
      b[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
    end
    run_op(a, b, 0, 0, 1, d1, d2, nd, r1, r2, ov1, rv1);
    e = sb_q.pop_front();
    checks++; if (r1 !== e.r) begin failures++; $display("FAIL snapshot_result got=%h exp=%h", r1, e.r); end
    checks++; if (ov1 !== e.ovf) begin failures++; $display("FAIL snapshot_ovf got=%b exp=%b", ov1, e.ovf); end
  endtask

  task automatic test_async_reset;
    int d1, d2, nd, seen_done; mat4_t r1, r2, b; bit ov1, rv1; exp_t e;
    seen_done = 0;
    @(negedge Clk);
    mat_a = {16{16'h7F00}}; mat_b = {16{16'h7F00}}; start = 1'b1;
    sb_q.push_back(model(mat_a, mat_b));
    @(posedge Clk); #1;
    start = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (done) seen_done++;
      @(posedge Clk); #1;
    end
    checks++; if (overflow !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL pre_reset got=ovf %b busy %b exp=1/1", overflow, busy); end
    #2 Reset = 1'b1;
    #1;
    sb_q.delete();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0 || overflow !== 1'b0)
      begin failures++; $display("FAIL async_reset_flags got=%b%b%b%b exp=0000", busy, done, result_valid, overflow); end
    checks++; if (result !== '0) begin failures++; $display("FAIL async_reset_result got=%h exp=0", result); end
    repeat (3) begin
      @(posedge Clk); #1;
      if (done) seen_done++;
    end
    @(negedge Clk) Reset = 1'b0;
    checks++; if (seen_done !== 0) begin failures++; $display("FAIL partial_done got=%0d exp=0", seen_done); end
    b = translate(16'h0100, 16'hFF00, 16'h0040);
    run_op(translate(16'h0000, 16'h0000, 16'h0000), b, 0, 0, 0, d1, d2, nd, r1, r2, ov1, rv1);
    e = sb_q.pop_front();
    checks++; if (d1 !== LAT || nd !== 1) begin failures++; $display("FAIL post_reset_done got=%0d x%0d exp=%0d x1", d1, nd, LAT); end
    checks++; if (r1 !== e.r || r1 !== b) begin failures++; $display("FAIL post_reset_result got=%h exp=%h", r1, b); end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; mat_a = '0; mat_b = '0;
    repeat (3) @(posedge Clk);
    #1;
    test_reset();
    @(negedge Clk) Reset = 1'b0;
    test_identity();
    test_translate();
    test_saturate();
    test_rounding();
    test_busy_start();
    test_back_to_back();
    test_input_change();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mat4_mul_seq.md
Name: mat4_mul_seq

Overview:
- Sequences a single shared fixed-point multiply-accumulate unit to compute a 4x4 matrix product R = A x B.
- Used to compose the MVP chain, e.g. view matrix x model matrix, then projection x result.
- Row-major 16-element matrices in signed Q(WI.WF); start/done handshake.
- Trades throughput for one multiplier instead of 64.

Parameters:
- WI, 8, integer bits (incl. sign) of operands and result.
- WF, 8, fractional bits of operands and result.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; accepted only in IDLE or DONE.
- mat_a  input  [15:0][WI+WF-1:0]  left operand, element r*4+c, row-major.
- mat_b  input  [15:0][WI+WF-1:0]  right operand, same layout.
- busy  output  1  high while a product is being computed.
- done  output  1  one-cycle pulse when result is complete.
- result_valid  output  1  result holds a complete product; sticky.
- result  output  [15:0][WI+WF-1:0]  product matrix, row-major.
- overflow  output  1  sticky; some element saturated during the current or last operation.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result_valid=0, overflow=0, all result elements=0, accumulator=0.
- States: IDLE, MAC, WRITE, DONE.
- Accept edge (start=1 in IDLE or DONE):
  - Snapshot mat_a and mat_b into internal registers; later input changes are ignored.
  - Clear accumulator, element index i=0, k=0, overflow=0, result_valid=0.
  - Enter MAC; busy=1 from the following cycle.
- MAC (4 cycles per element, k=0..3): acc += A[r*4+k] * B[k*4+c], where r=i/4, c=i%4.
  - Product is full precision, 2(WI+WF) bits.
  - Accumulator is 2(WI+WF)+2 bits; no intermediate rounding.
- WRITE (1 cycle):
  - out = (acc + 2^(WF-1)) >>> WF, i.e. round half toward +inf.
  - Saturate to [-2^(WI+WF-1), 2^(WI+WF-1)-1]; set overflow if clamped.
  - result[i] <= out.
  - If i<15: i++, k=0, acc=0, go to MAC. If i=15: go to DONE.
- Elements are written in index order 0..15. Intermediate result values are visible, but result_valid=0 until DONE.
- DONE (1 cycle): done=1, busy=0, result_valid=1. Then IDLE, unless start is high, in which case it is accepted immediately.
- Latency: accept edge at cycle 0 → MAC/WRITE in cycles 1..80 → done high in cycle 81. Throughput: one product per 81 cycles.
- start while busy: ignored, no queuing.
- result and result_valid hold until the next accepted start.
- Reset mid-operation aborts with no partial done. The next start after reset behaves normally.

Optional Feature:
- Macro: MAT4_MUL_SEQ_PIPE_MULT_EN.
- Defined:
  - A register is inserted between multiplier and accumulator, for timing closure at higher Clk.
  - Each element takes 4 multiply cycles + 1 drain cycle + WRITE = 6 cycles.
  - done appears in cycle 97. Arithmetic results are bit-identical.
- Undefined: 5 cycles per element, done in cycle 81 as above.

Decomposition:
- Package fxp_mat_pkg contains:
  - localparams N_ELEM=16 and N_DIM=4.
  - typedef mat4_t, a packed [15:0][WI+WF-1:0] with package-level default widths.
  - enum mat_seq_state_t {IDLE, MAC, WRITE, DONE}.
- Sub-module fxp_mac:
  - Signed multiplier plus accumulator with clear/enable.
  - Round-half-up and saturate output stage with an overflow flag.
  - Pipeline register selected by the macro.
- Top level holds the FSM, the i/k counters, operand snapshot and result registers.

Test Plan:
- A=identity (diag 0x0100), B=translate(-1,-2,-3) (B[3]=0xFF00, B[7]=0xFE00, B[11]=0xFD00) → result==B bit-exact, done pulse in cycle 81 only, overflow=0.
- A=translate(-1,-2,-3), B=translate(-4,0,0.5) → result[3]=0xFB00, result[7]=0xFE00, result[11]=0xFD80, diagonal 0x0100, all other elements 0x0000.
- All A and B elements 0x7F00 (127.0) → every result element 0x7FFF, overflow=1. Repeat with A elements 0x8000 and B elements 0x7F00 → every element 0x8000.
- Rounding: A[0]=0x0001, B[0]=0x0080, rest 0 → result[0]=0x0001. Then A[0]=0xFFFF → result[0]=0x0000. Both with overflow=0.
- Control:
  - start pulsed in cycle 20 while busy → ignored, single done at cycle 81.
  - start held high through DONE → back-to-back operation, second done at cycle 162.
  - mat_a changed mid-operation → no effect on result.
- Reset asserted asynchronously in cycle 40 → busy, done, result_valid, overflow and all result elements 0 immediately. A new start then completes correctly with done 81 cycles later.
